// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS datapath widths, register-index constants and types
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;
    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA   = 5'd31;
endpackage

// File: rtl/reg_read_port.sv
// reg_read_port: one combinational read port with r0 zeroing and write-first forwarding
module reg_read_port #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              fwd_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    output logic [DATA_W-1:0] rd_data
);
    import mips_pkg::*;
    // r0 wins, then a same-cycle write to this index, then the stored value
    always_comb begin
        rd_data = (rd_addr == ADDR_W'(REG_ZERO)) ? '0 :
                  (fwd_en && rd_addr == wr_addr) ? wr_data : regs[rd_addr];
    end
endmodule

// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 2R1W MIPS register file, r0 hardwired to zero, WB->ID forwarding
module reg_file_32x32 #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wr_ack
);
    import mips_pkg::*;
    localparam int DEPTH = 2**ADDR_W;
    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_v [DEPTH];
    logic              wr_hit;
    logic              wr_ack_q;
    assign wr_hit = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
    assign wr_ack = wr_ack_q;
    // Write decoder into r1..r31; ack reports a write that actually committed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
            wr_ack_q <= 1'b0;
        end else begin
            for (int i = 1; i < DEPTH; i++)
                if (wr_hit && wr_addr == ADDR_W'(i)) regs_q[i] <= wr_data;
            wr_ack_q <= wr_hit;
        end
    end
    // Full 32-entry view for the read muxes; slot 0 is a constant, not a flop
    always_comb begin
        regs_v[0] = '0;
        for (int i = 1; i < DEPTH; i++) regs_v[i] = regs_q[i];
    end
    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .rd_addr (rd_addr_a),
        .fwd_en  (wr_hit),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .regs    (regs_v),
        .rd_data (rd_data_a)
    );
    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .rd_addr (rd_addr_b),
        .fwd_en  (wr_hit),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .regs    (regs_v),
        .rd_data (rd_data_b)
    );
endmodule

// File: tb/tb_reg_file_32x32.sv
// tb_reg_file_32x32: directed scoreboard bench for the MIPS register file
module tb_reg_file_32x32;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        wr_ack;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl [32];

    reg_file_32x32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_ack    (wr_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: observed %h but scoreboard empty", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // Expected read value for an index given the current model and write inputs
    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wr_en && wr_addr != 5'd0 && wr_addr == a) return wr_data;
        return mdl[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    task automatic read_both(input string tag);
        exp_q.push_back(model_rd(rd_addr_a));
        exp_q.push_back(model_rd(rd_addr_b));
        #1;
        chk({tag, "_a"}, rd_data_a);
        chk({tag, "_b"}, rd_data_b);
    endtask

    // One clock edge: commit the model write, then check the ack pulse
    task automatic step(input string tag);
        logic hit;
        hit = wr_en && (wr_addr != 5'd0);
        if (hit) mdl[wr_addr] = wr_data;
        exp_q.push_back({31'b0, hit});
        @(posedge clk);
        #1;
        chk(tag, {31'b0, wr_ack});
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
        rd_addr_a = 5'd5; rd_addr_b = 5'd31;
        clear_model();
        #2;
        exp_q.push_back(32'h0);
        chk("reset_ack", {31'b0, wr_ack});
        read_both("reset_rd");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Async reset wipes r5 mid-cycle
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        step("w5_ack");
        wr_en = 1'b0; rd_addr_a = 5'd5;
        read_both("r5");
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        read_both("async_rst_rd");
        exp_q.push_back(32'h0);
        chk("async_rst_ack", {31'b0, wr_ack});
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain write then read on port B, ack is a single pulse
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
        step("w7_ack");
        wr_en = 1'b0; rd_addr_b = 5'd7; rd_addr_a = 5'd0;
        read_both("r7");
        step("w7_ack_drop");

        // Writes to r0 are dropped and never forwarded
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        read_both("r0_pre");
        step("r0_ack");
        read_both("r0_post");

        // Forwarding to both ports at once, then the stored value
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA_0000;
        step("w3_ack");
        wr_en = 1'b0; rd_addr_a = 5'd3; rd_addr_b = 5'd7;
        read_both("r3_old");
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h5555_1111; rd_addr_b = 5'd3;
        read_both("fwd_both");
        rd_addr_b = 5'd7;
        read_both("fwd_a_only");
        step("fwd_ack");
        wr_en = 1'b0; rd_addr_b = 5'd3;
        read_both("r3_new");

        // Back-to-back writes to every register
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = i * 32'h0101_0101;
            step("burst_ack");
        end
        wr_en = 1'b0;
        step("burst_ack_end");
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
            read_both("sweep1");
        end

        // Hold: random addresses/data with write disabled
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b0; wr_addr = 5'($urandom_range(0, 31)); wr_data = $urandom;
            step("hold_ack");
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
            read_both("sweep2");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_32x32.md
Name: reg_file_32x32

Overview:
- General-purpose register file for the MIPS datapath: 32 registers x 32 bits, two asynchronous read ports (rs, rt), one synchronous write port (rd from writeback).
- Sits between instruction decode and the ID/EX pipeline register.
- Receives write-back data from the WB stage and supplies operand A/B to the ID/EX latch.
- Register 0 is hardwired to zero.
- Read-after-write in the same cycle is forwarded internally, so WB->ID needs no external bypass.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- RESET_VAL, 32'h0000_0000, value loaded into registers 1..31 on reset.

Ports:
- clk  in  1  system clock; all writes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write enable from WB stage (RegWrite).
- wr_addr  in  ADDR_W  destination register index.
- wr_data  in  DATA_W  write-back value.
- rd_addr_a  in  ADDR_W  read port A index (rs).
- rd_addr_b  in  ADDR_W  read port B index (rt).
- rd_data_a  out  DATA_W  read port A value.
- rd_data_b  out  DATA_W  read port B value.
- wr_ack  out  1  registered pulse: a write to a nonzero register committed on the previous edge.

Behaviour:
- Reset: rst_n low asynchronously clears registers 1..31 to RESET_VAL and wr_ack to 0, regardless of clk. Reads during reset return RESET_VAL (or 0 for r0). Deassertion takes effect at the next rising edge; a write presented on that edge commits.
- Storage: 31 physical registers (r1..r31). r0 has no flop.
- Write: on rising clk with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. Latency 1 cycle.
- Ignored writes: wr_en=1 with wr_addr=0 is discarded silently. wr_en=0 holds all registers.
- wr_ack: <= wr_en && (wr_addr!=0) on each edge; a one-cycle pulse per committed write. Back-to-back writes hold it high continuously.
- Read timing: combinational, 0-cycle latency. Index 0 always returns 32'h0.
- Write-first forwarding: when wr_en=1, wr_addr!=0 and rd_addr_x==wr_addr, rd_data_x = wr_data in the same cycle, before the edge. This applies independently per port and to both ports at once.
- No forwarding when wr_addr=0.
- Read priority per port: (addr==0) -> 0; else forward hit -> wr_data; else stored value.
- X handling: an X/Z address on a read port drives X on that port only. Storage is unaffected.
- No read-side state: reads have no side effects and no enable.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ZERO = 5'd0, REG_RA = 5'd31
  - DATA_W / ADDR_W constants
  - typedef reg_addr_t (5 bits), typedef word_t (32 bits)
- One sub-module, reg_read_port, instantiated twice. It performs the per-port zero check, forward compare and 32:1 storage select.
- The write decoder and flops stay in the top module.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing r5=32'hDEAD_BEEF -> rd_data_a at addr 5 reads 0 immediately (asynchronous); wr_ack=0.
- Write/read: write r7=32'h1234_5678 -> next cycle rd_addr_b=7 returns 32'h1234_5678; wr_ack pulses high for one cycle.
- r0 protection: wr_en=1, wr_addr=0, wr_data=32'hFFFF_FFFF -> rd_addr_a=0 returns 0 both before and after the edge; wr_ack stays 0.
- Forwarding: r3 holds 32'hAAAA_0000; same cycle present wr_addr=3, wr_data=32'h5555_1111, rd_addr_a=3, rd_addr_b=3 -> both ports show 32'h5555_1111 before the edge, and the stored value matches after it.
- Independent ports, all addresses: write each r[i]=i*32'h0101_0101 for i=1..31 back-to-back -> wr_ack stays high 31 cycles; then sweep rd_addr_a=i, rd_addr_b=31-i and check every value.
- Hold: wr_en=0 with varying wr_addr/wr_data for 10 cycles -> no register changes; wr_ack=0.
